uart_tx: RTL and testbench

- UART serializer for the transmit path of the multi-clock system.
- Accepts a parallel byte from the TX-side synchronizer/FIFO read logic and shifts out one frame: start bit, DATA_WIDTH data bits LSB first, optional parity bit, stop bit.
- Runs on the divided TX clock from the DIV_RATIO_W clock divider. One CLK cycle equals one bit time.
- Complements the UART receiver that uses the PRESCALE_W oversampling clock.

---
 rtl/uart_tx_if.sv | 23 ++
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Parallel-side bundle for the UART transmitter: byte, valid and parity
// controls come from the producer; serial line and busy flag go back to it.
// The producer uses the master modport, uart_tx uses the slave modport.
interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;      // parallel byte to send
    logic                  DATA_VALID;  // P_DATA valid, sampled only while BUSY=0
    logic                  PAR_EN;      // 1 = append a parity bit
    logic                  PAR_TYP;     // 0 = even, 1 = odd
    logic                  TX_OUT;      // serial line, idles high
    logic                  BUSY;        // frame in progress

    modport master (
        output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        input  TX_OUT, BUSY
    );

    modport slave (
        input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
        output TX_OUT, BUSY
    );
endinterface

// File: rtl/uart_tx.sv
// UART frame serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit(s).
// Latency: start bit is on TX_OUT right after the edge that samples DATA_VALID; one bit per CLK.
// Backpressure: DATA_VALID is ignored while BUSY=1; producer holds or re-presents the byte.
//
// Ports: CLK (bit clock), RST (synchronous, active-high), tx_if (uart_tx_if.slave:
// P_DATA, DATA_VALID, PAR_EN, PAR_TYP in; TX_OUT, BUSY out, both registered).
// Build option: define UART_TX_STOP2_EN for two stop bits per frame.
module uart_tx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic     CLK,
    input  logic     RST,
    uart_tx_if.slave tx_if
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
`ifdef UART_TX_STOP2_EN
    logic                  stop_q, stop_d;   // 0 = first stop bit, 1 = second
`endif

    // State register (all frame state plus the registered line outputs)
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
`ifdef UART_TX_STOP2_EN
            stop_q    <= stop_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`ifdef UART_TX_STOP2_EN
        stop_d    = stop_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_if.DATA_VALID) begin
                    // Everything the frame needs is captured here, so later
                    // input changes cannot disturb the frame in flight.
                    state_d   = S_START;
                    data_d    = tx_if.P_DATA;
                    par_en_d  = tx_if.PAR_EN;
                    par_bit_d = (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
                    cnt_d     = '0;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
`ifdef UART_TX_STOP2_EN
                if (stop_q) begin
                    stop_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    stop_d  = 1'b1;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: decoded from the next state so TX_OUT/BUSY come straight
    // from flops and change on the same edge as the state.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = 1'b1;
        case (state_d)
            S_IDLE:   begin tx_d = 1'b1; busy_d = 1'b0; end
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = data_d[cnt_d];
            S_PARITY: tx_d = par_bit_d;
            S_STOP:   tx_d = 1'b1;
            default:  begin tx_d = 1'b1; busy_d = 1'b0; end
        endcase
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected frames are built from the frame
// rules (start, data LSB first, parity from a count of ones, stop bits).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_STOP2_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic CLK = 1'b0;
    logic RST;

    uart_tx_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx #(.DATA_WIDTH(DW)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (bus.slave)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;
    bit exp_q[$];

    // Reference frame: the bit sequence a listener on the line should see.
    function automatic void model_frame(input logic [DW-1:0] d, input bit pe, input bit pt);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < DW; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        // Parity bit makes the total number of ones even (pt=0) or odd (pt=1).
        if (pe) exp_q.push_back(bit'((ones + int'(pt)) % 2));
        for (int i = 0; i < NSTOP; i++) exp_q.push_back(1'b1);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.DATA_VALID = 1'b0;
        bus.P_DATA = '0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        tick();
        tick();
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: tx=%b busy=%b, expected tx=1 busy=0", i, bus.TX_OUT, bus.BUSY);
            end
        end
    endtask

    task automatic test_even_parity();
        bus.P_DATA = 8'hA5;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        bus.DATA_VALID = 1'b1;
        model_frame(8'hA5, 1'b1, 1'b0);
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL even_par bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            tick();
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL even_par end: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
    endtask

    task automatic test_odd_back_to_back();
        logic [DW-1:0] d2;
        d2 = DW'($urandom);
        bus.P_DATA = 8'h80;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b1;
        bus.DATA_VALID = 1'b1;
        model_frame(8'h80, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL odd_b2b f1 bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            if (i == 3) bus.P_DATA = d2;
            tick();
        end
        // Exactly one idle cycle between frames even with DATA_VALID held.
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL odd_b2b gap: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
        model_frame(d2, 1'b1, 1'b1);
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL odd_b2b f2 bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            tick();
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL odd_b2b end: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
    endtask

    task automatic test_no_parity_noise();
        bit pt;
        pt = bit'($urandom % 2);
        bus.P_DATA = 8'h3C;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = pt;
        bus.DATA_VALID = 1'b1;
        model_frame(8'h3C, 1'b0, pt);
        tick();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL no_par bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            // Inputs wiggle mid-frame; the frame must not notice.
            bus.DATA_VALID = 1'($urandom % 2);
            bus.P_DATA = DW'($urandom);
            bus.PAR_EN = 1'($urandom % 2);
            bus.PAR_TYP = 1'($urandom % 2);
            tick();
        end
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
                errors++;
                $display("FAIL no_par idle%0d: tx=%b busy=%b, expected tx=1 busy=0", i, bus.TX_OUT, bus.BUSY);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [DW-1:0] d;
        bit pe, pt;
        pe = bit'($urandom % 2);
        pt = bit'($urandom % 2);
        bus.P_DATA = 8'h00;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.DATA_VALID = 1'b1;
        model_frame(8'h00, pe, pt);
        tick();
        bus.DATA_VALID = 1'b0;
        // Indices 0..5 cover start bit through data bit 4.
        for (int i = 0; i <= 5; i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            if (i < 5) tick();
        end
        RST = 1'b1;
        tick();
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid abort: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid no_resume%0d: tx=%b busy=%b, expected tx=1 busy=0", i, bus.TX_OUT, bus.BUSY);
            end
        end
        d = DW'($urandom);
        bus.P_DATA = d;
        bus.DATA_VALID = 1'b1;
        model_frame(d, pe, pt);
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid fresh bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            tick();
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid end: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] d;
        bit pe, pt;
        int gap;
        for (int f = 0; f < 30; f++) begin
            d = DW'($urandom);
            pe = bit'($urandom % 2);
            pt = bit'($urandom % 2);
            gap = int'($urandom_range(0, 3));
            bus.P_DATA = d;
            bus.PAR_EN = pe;
            bus.PAR_TYP = pt;
            bus.DATA_VALID = 1'b1;
            model_frame(d, pe, pt);
            tick();
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                    errors++;
                    $display("FAIL rand f%0d bit%0d: tx=%b busy=%b, expected tx=%b busy=1 (d=%h pe=%b pt=%b)",
                             f, i, bus.TX_OUT, bus.BUSY, exp_q[i], d, pe, pt);
                end
                bus.DATA_VALID = 1'($urandom % 2);
                bus.P_DATA = DW'($urandom);
                bus.PAR_EN = 1'($urandom % 2);
                bus.PAR_TYP = 1'($urandom % 2);
                tick();
            end
            bus.DATA_VALID = 1'b0;
            for (int g = 0; g <= gap; g++) begin
                checks++;
                if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
                    errors++;
                    $display("FAIL rand f%0d idle%0d: tx=%b busy=%b, expected tx=1 busy=0", f, g, bus.TX_OUT, bus.BUSY);
                end
                if (g < gap) tick();
            end
        end
    endtask

`ifdef UART_TX_STOP2_EN
    task automatic test_stop2();
        bus.P_DATA = 8'hFF;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        bus.DATA_VALID = 1'b1;
        model_frame(8'hFF, 1'b0, 1'b0);
        tick();
        bus.DATA_VALID = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (bus.TX_OUT !== exp_q[i] || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL stop2 bit%0d: tx=%b busy=%b, expected tx=%b busy=1", i, bus.TX_OUT, bus.BUSY, exp_q[i]);
            end
            tick();
        end
        checks++;
        if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL stop2 end: tx=%b busy=%b, expected tx=1 busy=0", bus.TX_OUT, bus.BUSY);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_even_parity();
        test_odd_back_to_back();
        test_no_parity_noise();
        test_reset_mid_frame();
        test_random_frames();
`ifdef UART_TX_STOP2_EN
        test_stop2();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
